// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified memory-port arbiter: funct3-style
//   access width codes, arbiter FSM state encoding and the round-robin
//   "last granted" markers.
package mem_port_arbiter_pkg;

    // Access width codes, as carried on d_width / mem_width.
    localparam logic [2:0] MEM_W_B  = 3'd0;
    localparam logic [2:0] MEM_W_H  = 3'd1;
    localparam logic [2:0] MEM_W_W  = 3'd2;
    localparam logic [2:0] MEM_W_D  = 3'd3;
    localparam logic [2:0] MEM_W_BU = 3'd4;
    localparam logic [2:0] MEM_W_HU = 3'd5;
    localparam logic [2:0] MEM_W_WU = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    // Which requester received the most recent grant.
    typedef enum logic {
        RR_INSTR = 1'b0,
        RR_DATA  = 1'b1
    } rr_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three handshakes around the arbiter: instruction fetch
//   (if_*), load/store (d_*) and the shared memory port (mem_*).
//   slave  : arbiter view (takes requests and memory completions,
//            drives ready pulses and the memory request).
//   master : environment view (fetch unit, LSU and memory macro).
interface mem_port_arbiter_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
);
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_ready;
    logic [INSTR_W-1:0] if_rdata;
    logic               if_err;

    logic               d_req;
    logic               d_we;
    logic [2:0]         d_width;
    logic [ADDR_W-1:0]  d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic               d_ready;
    logic [DATA_W-1:0]  d_rdata;
    logic               d_err;

    logic               mem_req;
    logic               mem_we;
    logic [2:0]         mem_width;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_ack;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata, if_err,
        input  d_req, d_we, d_width, d_addr, d_wdata,
        output d_ready, d_rdata, d_err,
        output mem_req, mem_we, mem_width, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata, if_err,
        output d_req, d_we, d_width, d_addr, d_wdata,
        input  d_ready, d_rdata, d_err,
        input  mem_req, mem_we, mem_width, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_align_check.sv
// mem_align_check
//   Combinational legality check for a request about to be granted.
//   addr_i     : low three address bits of the request
//   width_i    : width code (fetches are always a word)
//   is_fetch_i : 1 for instruction fetch, 0 for load/store
//   bad_o      : 1 when the access is misaligned or the width code is illegal
module mem_align_check
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0] addr_i,
    input  logic [2:0] width_i,
    input  logic       is_fetch_i,
    output logic       bad_o
);

    always_comb begin
        bad_o = 1'b0;
        if (is_fetch_i) begin
            bad_o = |addr_i[1:0];
        end else begin
            case (width_i)
                MEM_W_B, MEM_W_BU: bad_o = 1'b0;
                MEM_W_H, MEM_W_HU: bad_o = addr_i[0];
                MEM_W_W, MEM_W_WU: bad_o = |addr_i[1:0];
                MEM_W_D:           bad_o = |addr_i[2:0];
                default:           bad_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and load/store with
//   round-robin arbitration under contention, alignment rejection and an
//   ack watchdog. Every output is a register.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : fetch, data and memory handshakes (mem_port_arbiter_if.slave)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 255
)(
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    rr_e                rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rej_q, rej_d;

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [2:0]         mem_width_q, mem_width_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic               if_ready_q, if_ready_d;
    logic [INSTR_W-1:0] if_rdata_q, if_rdata_d;
    logic               if_err_q, if_err_d;
    logic               d_ready_q, d_ready_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               d_err_q, d_err_d;

    logic               pick_d;
    logic [2:0]         chk_addr;
    logic [2:0]         chk_width;
    logic               bad;
    logic               fin;
    logic               fin_ok;

    // Data wins when it is alone, or when both ask and fetch went last.
    assign pick_d    = bus.d_req && (!bus.if_req || rr_q == RR_INSTR);
    assign chk_addr  = pick_d ? bus.d_addr[2:0] : bus.if_addr[2:0];
    assign chk_width = pick_d ? bus.d_width : MEM_W_W;

    mem_align_check u_align (
        .addr_i     (chk_addr),
        .width_i    (chk_width),
        .is_fetch_i (!pick_d),
        .bad_o      (bad)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        rej_d       = rej_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_width_d = mem_width_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        fin         = 1'b0;
        fin_ok      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    rr_d      = pick_d ? RR_DATA : RR_INSTR;
                    cnt_d     = '0;
                    // A rejected request still spends one cycle in BUSY with
                    // mem_req low, so error responses line up with a
                    // zero-wait memory completion.
                    rej_d     = bad;
                    mem_req_d = !bad;
                    if (pick_d) begin
                        mem_we_d    = bus.d_we;
                        mem_width_d = bus.d_width;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        state_d     = ST_BUSY_D;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_width_d = MEM_W_W;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        state_d     = ST_BUSY_I;
                    end
                end
            end

            ST_BUSY_I, ST_BUSY_D: begin
                // An ack in the last watchdog cycle still completes normally.
                if (!rej_q && bus.mem_ack) begin
                    fin    = 1'b1;
                    fin_ok = 1'b1;
                end else if (rej_q || cnt_q == CNT_LAST) begin
                    fin    = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                end

                if (fin) begin
                    mem_req_d = 1'b0;
                    rej_d     = 1'b0;
                    state_d   = ST_RESP;
                    if (state_q == ST_BUSY_D) begin
                        d_ready_d = 1'b1;
                        d_err_d   = !fin_ok;
                        d_rdata_d = (fin_ok && !mem_we_q) ? bus.mem_rdata : '0;
                    end else begin
                        if_ready_d = 1'b1;
                        if_err_d   = !fin_ok;
                        if_rdata_d = fin_ok ? bus.mem_rdata[INSTR_W-1:0] : '0;
                    end
                end
            end

            // No arbitration here: a request still held high during the
            // response cycle is not issued twice.
            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= RR_INSTR;
            cnt_q       <= '0;
            rej_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_width_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            rej_q       <= rej_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_width_q <= mem_width_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_width = mem_width_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives fetch and data requesters plus a memory responder around
//   mem_port_arbiter and compares every response against a
//   transaction-level model of the arbitration, alignment and watchdog rules.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int IW = 32;
    localparam int TO = 4;

    typedef struct {
        bit          fetch;
        bit          we;
        logic [2:0]  width;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] rd;
        int          k;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   rr_last = 1'b0;   // 0: fetch granted last, 1: data granted last
    mem_exp_t mq[$];

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic bit fetch_ok(input logic [11:0] a);
        return (int'(a) % 4) == 0;
    endfunction

    function automatic bit data_ok(input logic [2:0] w, input logic [11:0] a);
        int size;
        if (int'(w) >= 7) return 1'b0;
        case (int'(w) % 4)
            0: size = 1;
            1: size = 2;
            2: size = 4;
            default: size = 8;
        endcase
        return (int'(a) % size) == 0;
    endfunction

    // Memory responder: acks k cycles into each access, checks the
    // presented fields against the model's grant order, and throws in
    // stray acks while no access is outstanding.
    initial begin
        mem_exp_t cur;
        bit       active = 1'b0;
        int       mcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!rst) begin
                active = 1'b0;
                mq.delete();
            end else if (bus.mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    mcnt   = 0;
                    if (mq.size() == 0) begin
                        chk("memreq_unexpected", 64'd1, 64'd0);
                        cur = '{fetch: 1'b1, we: 1'b0, width: 3'd2, addr: 12'h0,
                                wdata: 64'h0, rd: 64'h0, k: 0};
                    end else begin
                        cur = mq.pop_front();
                    end
                end
                chk("mem_we", bus.mem_we, cur.we);
                chk("mem_width", bus.mem_width, cur.width);
                chk("mem_addr", bus.mem_addr, cur.addr);
                if (!cur.fetch) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                if (mcnt == cur.k) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = cur.rd;
                end
                mcnt++;
            end else begin
                if (active) begin
                    chk("memreq_len", mcnt, (cur.k < TO) ? cur.k + 1 : TO);
                    active = 1'b0;
                end
                if ($urandom_range(7) == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = {$urandom, $urandom};
                end
            end
        end
    end

    task automatic push_i(input logic [11:0] ia, input int ik, input logic [63:0] ird);
        mq.push_back('{fetch: 1'b1, we: 1'b0, width: 3'd2, addr: ia,
                       wdata: 64'h0, rd: ird, k: ik});
    endtask

    task automatic push_d(input bit dwe, input logic [2:0] dw, input logic [11:0] da,
                          input logic [63:0] dwd, input int dk, input logic [63:0] drd);
        mq.push_back('{fetch: 1'b0, we: dwe, width: dw, addr: da,
                       wdata: dwd, rd: drd, k: dk});
    endtask

    // One scenario: optionally a fetch and/or a data request raised in the
    // same cycle, each held until its ready pulse.
    task automatic run_scn(input bit do_i, input logic [11:0] ia, input int ik,
                           input logic [63:0] ird,
                           input bit do_d, input bit dwe, input logic [2:0] dw,
                           input logic [11:0] da, input logic [63:0] dwd,
                           input int dk, input logic [63:0] drd);
        int issue, exp_i, exp_d, ke_i, ke_d, budget;
        bit bad_i, bad_d, err_i, err_d, first_d, pend_i, pend_d;
        logic [63:0] xr_i, xr_d;

        @(posedge clk); #1;
        issue = cyc;
        bus.if_req  = do_i;
        bus.if_addr = ia;
        bus.d_req   = do_d;
        bus.d_we    = dwe;
        bus.d_width = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;

        bad_i = !fetch_ok(ia);
        bad_d = !data_ok(dw, da);
        err_i = bad_i || ik >= TO;
        err_d = bad_d || dk >= TO;
        ke_i  = bad_i ? 0 : ((ik >= TO) ? TO - 1 : ik);
        ke_d  = bad_d ? 0 : ((dk >= TO) ? TO - 1 : dk);
        xr_i  = err_i ? 64'h0 : {32'h0, ird[31:0]};
        xr_d  = (err_d || dwe) ? 64'h0 : drd;
        first_d = do_d && (!do_i || rr_last == 1'b0);
        exp_i = 0;
        exp_d = 0;

        if (first_d) begin
            exp_d = issue + 2 + ke_d;
            if (!bad_d) push_d(dwe, dw, da, dwd, dk, drd);
            rr_last = 1'b1;
            if (do_i) begin
                exp_i = exp_d + 3 + ke_i;
                if (!bad_i) push_i(ia, ik, ird);
                rr_last = 1'b0;
            end
        end else if (do_i) begin
            exp_i = issue + 2 + ke_i;
            if (!bad_i) push_i(ia, ik, ird);
            rr_last = 1'b0;
            if (do_d) begin
                exp_d = exp_i + 3 + ke_d;
                if (!bad_d) push_d(dwe, dw, da, dwd, dk, drd);
                rr_last = 1'b1;
            end
        end

        pend_i = do_i;
        pend_d = do_d;
        budget = 0;
        while ((pend_i || pend_d) && budget < 100) begin
            @(negedge clk);
            budget++;
            if (bus.if_ready) begin
                if (pend_i) begin
                    chk("if_ready_cycle", cyc, exp_i);
                    chk("if_err", bus.if_err, err_i);
                    chk("if_rdata", {32'h0, bus.if_rdata}, xr_i);
                    pend_i = 1'b0;
                    bus.if_req = 1'b0;
                end else begin
                    chk("if_ready_extra", 64'd1, 64'd0);
                end
            end
            if (bus.d_ready) begin
                if (pend_d) begin
                    chk("d_ready_cycle", cyc, exp_d);
                    chk("d_err", bus.d_err, err_d);
                    chk("d_rdata", bus.d_rdata, xr_d);
                    pend_d = 1'b0;
                    bus.d_req = 1'b0;
                end else begin
                    chk("d_ready_extra", 64'd1, 64'd0);
                end
            end
        end
        if (pend_i || pend_d) chk("ready_wait_expired", 64'd1, 64'd0);
        @(negedge clk);
        chk("ready_one_cycle", {bus.if_ready, bus.d_ready}, 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return {54'h0, bus.mem_req, bus.mem_we, bus.if_ready, bus.if_err,
                bus.d_ready, bus.d_err,
                |bus.mem_width, |bus.mem_addr, |bus.mem_wdata,
                |bus.if_rdata | |bus.d_rdata};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_time_limit act=%0d exp=0", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_width = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b1;

        // Contention from reset exit: expected grant order D, I, D, I.
        run_scn(1'b1, 12'h040, 0, 64'h0000_0000_1234_5678,
                1'b1, 1'b0, 3'd3, 12'h080, 64'h0, 0, 64'hA5A5_0000_FFFF_0001);
        run_scn(1'b1, 12'h044, 0, 64'h0000_0000_8765_4321,
                1'b1, 1'b0, 3'd2, 12'h084, 64'h0, 0, 64'h0000_0000_0BAD_F00D);

        // Single fetch, ack two cycles after mem_req.
        run_scn(1'b1, 12'h010, 2, 64'h0000_0000_0000_0013,
                1'b0, 1'b0, 3'd0, 12'h0, 64'h0, 0, 64'h0);

        // Misaligned doubleword load.
        run_scn(1'b0, 12'h0, 0, 64'h0,
                1'b1, 1'b0, 3'd3, 12'h004, 64'h0, 0, 64'hDEAD_BEEF_0000_0001);

        // Illegal width code.
        run_scn(1'b0, 12'h0, 0, 64'h0,
                1'b1, 1'b0, 3'd7, 12'h000, 64'h0, 0, 64'h1);

        // Byte store pass-through.
        run_scn(1'b0, 12'h0, 0, 64'h0,
                1'b1, 1'b1, 3'd0, 12'h123, 64'h0000_0000_0000_00AB, 1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Watchdog: memory never acks.
        run_scn(1'b0, 12'h0, 0, 64'h0,
                1'b1, 1'b0, 3'd2, 12'h100, 64'h0, 50, 64'h0);

        // Reset in the middle of a data access.
        @(posedge clk); #1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_width = 3'd3;
        bus.d_addr  = 12'h008;
        bus.d_wdata = 64'h0;
        push_d(1'b0, 3'd3, 12'h008, 64'h0, 100, 64'h0);
        repeat (3) @(negedge clk);
        chk("pre_reset_mem_req", bus.mem_req, 1'b1);
        #2;
        rst = 1'b0;
        bus.d_req = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 64'd0);
        rr_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_scn(1'b1, 12'h020, 1, 64'h0000_0000_CAFE_0001,
                1'b1, 1'b0, 3'd1, 12'h00A, 64'h0, 1, 64'h0000_0000_0000_BEEF);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int mode;
            logic [11:0] ia, da;
            logic [2:0]  dw;
            mode = $urandom_range(1, 3);
            ia = 12'($urandom);
            if ($urandom_range(3) != 0) ia[1:0] = 2'b00;
            dw = 3'($urandom_range(7));
            da = 12'($urandom);
            if ($urandom_range(3) != 0) da[2:0] = 3'b000;
            run_scn(mode[0], ia, $urandom_range(5), {$urandom, $urandom},
                    mode[1], 1'($urandom), dw, da, {$urandom, $urandom},
                    $urandom_range(5), {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction fetch and the load/store path.
- Lets the core run from a single physical memory instead of separate instruction and data memories.
- Sits between the PC/fetch logic and data access on one side, and the memory macro on the other.
- Fair two-way arbitration, request/ready handshakes, misalignment rejection and an ack watchdog.

Parameters:
ADDR_W, 12, byte-address width of the shared memory.
DATA_W, 64, data-path width; must equal `DATA_WIDTH.
INSTR_W, 32, instruction width; must equal `INSTR_WIDTH.
TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting; must be ≥1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  ADDR_W  fetch byte address
if_ready  out  1  one-cycle response pulse for fetch
if_rdata  out  INSTR_W  fetched instruction, valid with if_ready
if_err  out  1  fetch error, valid with if_ready
d_req  in  1  data request; held with all d_* until d_ready
d_we  in  1  1 = store, 0 = load
d_width  in  3  funct3-style width code: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_ready  out  1  one-cycle response pulse for data
d_rdata  out  DATA_W  load data, valid with d_ready
d_err  out  1  data error, valid with d_ready
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_width  out  3  width code forwarded to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion
mem_rdata  in  DATA_W  memory read data, valid with mem_ack

Behaviour:
- All outputs are registered.
- While rst=0: state=IDLE; every output is 0; wait counter=0; rr_last=INSTR.
- Reset asserted mid-transaction aborts it immediately. No ready pulse is produced. The requester must re-issue after reset.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE arbitration:
  - Only if_req: grant fetch.
  - Only d_req: grant data.
  - Both: grant the requester not equal to rr_last.
  - Update rr_last on every grant.
- On grant:
  - Latch the requester's fields into mem_* (fetch: we=0, width=2).
  - Misalignment check: fetch needs addr[1:0]=0; data needs addr aligned to 1/2/4/8 bytes per width code.
  - Width codes 7 and above are illegal.
  - Misaligned or illegal: go straight to RESP with err=1 and rdata=0. mem_req is never asserted.
  - Otherwise: go to BUSY_I or BUSY_D with mem_req=1 and counter=0.
- BUSY_*:
  - mem_req and all mem_* stay stable; counter increments each cycle.
  - On mem_ack: capture read data and go to RESP with err=0. Fetch takes mem_rdata[INSTR_W-1:0]; data takes the full mem_rdata.
  - Stores return rdata=0.
  - If counter reaches TIMEOUT-1 without mem_ack: drop mem_req and go to RESP with err=1, rdata=0.
  - mem_ack in that same cycle wins over the timeout.
  - mem_req deasserts in the cycle after mem_ack is seen.
- RESP:
  - Exactly one cycle of if_ready or d_ready, matching the grant.
  - No arbitration occurs in RESP, so a still-high req cannot double-issue.
  - Next state is always IDLE.
- Latency: req seen in IDLE at cycle t; mem_req high at t+1; ack at t+1+k; ready at t+2+k. Minimum 3 cycles with k=0.
- Error path latency: ready at t+2.
- mem_ack outside BUSY_* is ignored.
- Requester inputs changing before ready is a protocol violation. Only the values latched at grant are used.

Decomposition:
- Shared package/header (riscv64 include):
  - width codes (MEM_W_B … MEM_W_WU)
  - arbiter state encodings
  - RR_INSTR/RR_DATA constants
- One sub-module, mem_align_check (combinational):
  - inputs: addr[2:0], width, is_fetch
  - output: misaligned/illegal flag
- Arbiter FSM, counter and registers stay in mem_port_arbiter.

Test Plan:
- Single fetch: if_req=1, if_addr=0x010, mem_ack 2 cycles after mem_req, mem_rdata=0x00000013 → mem_addr=0x010, mem_we=0, mem_width=2; if_ready pulses at t+4 with if_rdata=0x00000013, if_err=0.
- Contention fairness: if_req and d_req held high from reset exit (each re-requests after ready), ack with zero wait → grant order D, I, D, I; each ready is exactly one cycle; no double issue.
- Misaligned load: d_req, d_width=3, d_addr=0x004 → mem_req stays 0; d_ready at t+2 with d_err=1, d_rdata=0.
- Store pass-through: d_we=1, d_width=0, d_addr=0x123, d_wdata=0xAB → mem_we=1, mem_width=0, mem_addr=0x123, mem_wdata=0xAB held until ack; d_ready with d_rdata=0.
- Timeout: TIMEOUT=4, mem_ack never asserted → mem_req high for exactly 4 cycles; d_ready with d_err=1; state returns to IDLE.
- Reset mid-access: rst low during BUSY_D → mem_req=0 and all ready outputs 0 immediately (asynchronous); after release, first contended grant goes to data.
